// File: rtl/decode_hazard_scheduler.sv
// Scoreboard issue scheduler for the decode stage: tracks pending scalar/vector
// register writes and drives stall, bubble, issue and post-branch flush controls.
module decode_hazard_scheduler #(
    parameter int SCALAR_LAT     = 3,
    parameter int LOAD_LAT       = 4,
    parameter int VECTOR_LAT     = 6,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_ra,
    input  logic [3:0]  id_rb,
    input  logic [3:0]  id_rc,
    input  logic        id_modeSel,
    input  logic        id_immSrc,
    input  logic        id_regWrite,
    input  logic        id_regWriteV,
    input  logic        id_memToReg,
    input  logic        id_memWrite,
    input  logic        id_branchFlag,
    output logic        stall,
    output logic        bubble,
    output logic        issue,
    output logic        flush,
    output logic [15:0] busyS,
    output logic [15:0] busyV
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_s_q [16];
    logic [CNT_W-1:0] cnt_s_d [16];
    logic [CNT_W-1:0] cnt_v_q [16];
    logic [CNT_W-1:0] cnt_v_d [16];
    logic [15:0]      src_busy;
    logic             hazard;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            busyS[i] = (cnt_s_q[i] != '0);
            busyV[i] = (cnt_v_q[i] != '0);
        end
    end

    // Sources read from the file picked by modeSel; WAW checks use the destination's own file.
    always_comb begin
        src_busy = id_modeSel ? busyV : busyS;
        hazard   = id_valid && (src_busy[id_ra]
                              || (!id_immSrc   && src_busy[id_rb])
                              || (id_memWrite  && src_busy[id_rc])
                              || (id_regWrite  && busyS[id_rc])
                              || (id_regWriteV && busyV[id_rc]));
    end

    always_comb begin
        stall  = 1'b0;
        issue  = 1'b0;
        bubble = 1'b1;
        flush  = 1'b0;
        if (rst) begin
            if (state_q == FLUSH) begin
                flush = 1'b1;
            end else begin
                stall  = hazard;
                issue  = id_valid && !hazard;
                bubble = !issue;
            end
        end
    end

    // A load on issue takes priority over the saturating decrement.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cnt_s_d[i] = (cnt_s_q[i] != '0) ? cnt_s_q[i] - CNT_W'(1) : '0;
            cnt_v_d[i] = (cnt_v_q[i] != '0) ? cnt_v_q[i] - CNT_W'(1) : '0;
        end
        if (issue && id_regWrite)
            cnt_s_d[id_rc] = id_memToReg ? CNT_W'(LOAD_LAT) : CNT_W'(SCALAR_LAT);
        if (issue && id_regWriteV)
            cnt_v_d[id_rc] = CNT_W'(VECTOR_LAT);
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (issue && id_branchFlag && (BRANCH_PENALTY != 0)) begin
                    state_d = FLUSH;
                    fcnt_d  = CNT_W'(BRANCH_PENALTY);
                end
            end
            FLUSH: begin
                if (fcnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt_s_q[i] <= '0;
                cnt_v_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            for (int i = 0; i < 16; i++) begin
                cnt_s_q[i] <= cnt_s_d[i];
                cnt_v_q[i] <= cnt_v_d[i];
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_scheduler.sv
// Directed bench for decode_hazard_scheduler: hand-computed stall/issue/flush
// timing and busy-flag values across RAW, WAW, load, vector, branch and reset cases.
module tb_decode_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_ra, id_rb, id_rc;
    logic        id_modeSel, id_immSrc, id_regWrite, id_regWriteV;
    logic        id_memToReg, id_memWrite, id_branchFlag;
    logic        stall, bubble, issue, flush;
    logic [15:0] busyS, busyV;

    int checks = 0;
    int errors = 0;

    decode_hazard_scheduler dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_ra(id_ra), .id_rb(id_rb), .id_rc(id_rc),
        .id_modeSel(id_modeSel), .id_immSrc(id_immSrc),
        .id_regWrite(id_regWrite), .id_regWriteV(id_regWriteV),
        .id_memToReg(id_memToReg), .id_memWrite(id_memWrite),
        .id_branchFlag(id_branchFlag),
        .stall(stall), .bubble(bubble), .issue(issue), .flush(flush),
        .busyS(busyS), .busyV(busyV)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one decoded instruction and let the combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [3:0] rc, input logic mode, input logic imm,
                                 input logic rw, input logic rwv, input logic m2r,
                                 input logic mw, input logic br);
        id_valid = v;  id_ra = ra;  id_rb = rb;  id_rc = rc;
        id_modeSel = mode;  id_immSrc = imm;  id_regWrite = rw;
        id_regWriteV = rwv; id_memToReg = m2r; id_memWrite = mw;
        id_branchFlag = br;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic es, input logic eb,
                               input logic ei, input logic ef);
        logic [3:0] obs, exp;
        obs = {stall, bubble, issue, flush};
        exp = {es, eb, ei, ef};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s ctl{stall,bubble,issue,flush}: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkBusy(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two edges with a valid instruction present.
        rst = 1'b0;
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("reset_c0", 0, 1, 0, 0);
        nextCycle();
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("reset_c1", 0, 1, 0, 0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        checkBusy("post_reset_S", busyS, 16'h0000);
        checkBusy("post_reset_V", busyV, 16'h0000);
        checkOutput("post_reset_idle", 0, 1, 0, 0);

        // add r3,r1,r2 then dependent add r4,r3,r1.
        applyStimulus(1, 4'd1, 4'd2, 4'd3, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("add_r3_issue", 0, 0, 1, 0);
        nextCycle();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 4'd3, 4'd1, 4'd4, 0, 0, 1, 0, 0, 0, 0);
            checkOutput($sformatf("raw_r3_stall_t%0d", k), 1, 1, 0, 0);
            checkBusy($sformatf("raw_r3_busy_t%0d", k), busyS, 16'h0008);
            nextCycle();
        end
        applyStimulus(1, 4'd3, 4'd1, 4'd4, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("raw_r3_issue_t4", 0, 0, 1, 0);
        checkBusy("raw_r3_clear_t4", busyS, 16'h0000);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("idle_drain_%0d", k), 0, 1, 0, 0);
            nextCycle();
        end
        applyStimulus(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        checkBusy("r4_drained", busyS, 16'h0000);

        // ld r15,[r0+r4] then add r1,r15,r2, then st with rc=r1.
        applyStimulus(1, 4'd0, 4'd4, 4'd15, 0, 0, 1, 0, 1, 0, 0);
        checkOutput("ld_issue", 0, 0, 1, 0);
        nextCycle();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 4'd15, 4'd2, 4'd1, 0, 0, 1, 0, 0, 0, 0);
            checkOutput($sformatf("load_use_stall_t%0d", k), 1, 1, 0, 0);
            checkBusy($sformatf("load_use_busy_t%0d", k), busyS, 16'h8000);
            nextCycle();
        end
        applyStimulus(1, 4'd15, 4'd2, 4'd1, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("load_use_issue_t5", 0, 0, 1, 0);
        nextCycle();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("store_rc_stall_%0d", k), 1, 1, 0, 0);
            checkBusy($sformatf("store_rc_busy_%0d", k), busyS, 16'h0002);
            nextCycle();
        end
        applyStimulus(1, 4'd0, 4'd2, 4'd1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("store_issue", 0, 0, 1, 0);
        nextCycle();

        // addv r2,r3,r5; scalar add r7,r2,r1 ignores busyV; mulv r6,r2,r1 waits.
        applyStimulus(1, 4'd3, 4'd5, 4'd2, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("addv_issue", 0, 0, 1, 0);
        nextCycle();
        applyStimulus(1, 4'd2, 4'd1, 4'd7, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("scalar_r2_no_stall", 0, 0, 1, 0);
        checkBusy("addv_busyV", busyV, 16'h0004);
        nextCycle();
        for (int k = 2; k <= 6; k++) begin
            applyStimulus(1, 4'd2, 4'd1, 4'd6, 1, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("mulv_stall_t%0d", k), 1, 1, 0, 0);
            checkBusy($sformatf("mulv_busyV_t%0d", k), busyV, 16'h0004);
            nextCycle();
        end
        applyStimulus(1, 4'd2, 4'd1, 4'd6, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("mulv_issue_t7", 0, 0, 1, 0);
        checkBusy("mulv_busyV_t7", busyV, 16'h0000);
        nextCycle();

        // Unconditional branch opens a two-cycle flush window.
        applyStimulus(1, 4'd0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 0, 1);
        checkOutput("branch_issue", 0, 0, 1, 0);
        nextCycle();
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(1, 4'd9, 4'd10, 4'd8, 0, 0, 1, 0, 0, 0, 0);
            checkOutput($sformatf("flush_t%0d", k), 0, 1, 0, 1);
            nextCycle();
        end
        applyStimulus(1, 4'd9, 4'd10, 4'd8, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("post_flush_issue", 0, 0, 1, 0);
        nextCycle();

        // Vector-writing branch, then reset inside the flush window.
        applyStimulus(1, 4'd3, 4'd0, 4'd2, 1, 1, 0, 1, 0, 0, 1);
        checkOutput("branchv_issue", 0, 0, 1, 0);
        nextCycle();
        applyStimulus(1, 4'd9, 4'd10, 4'd8, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("branchv_flush", 0, 1, 0, 1);
        checkBusy("branchv_busyV2", {15'd0, busyV[2]}, 16'h0001);
        rst = 1'b0;
        #1;
        checkOutput("midrun_reset_override", 0, 1, 0, 0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1, 4'd2, 4'd6, 4'd5, 1, 0, 0, 1, 0, 0, 0);
        checkBusy("after_reset_S", busyS, 16'h0000);
        checkBusy("after_reset_V", busyV, 16'h0000);
        checkOutput("after_reset_issue", 0, 0, 1, 0);
        nextCycle();

        // WAW: another vector write to busy r5 must stall.
        applyStimulus(1, 4'd0, 4'd1, 4'd5, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("waw_v5_stall", 1, 1, 0, 0);
        checkBusy("waw_busyV", busyV, 16'h0020);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
